// File: rtl/mips_pc_defs.sv
// mips_pc_defs: fetch-stage FSM state encodings and default reset/trap addresses
package mips_pc_defs;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, TRAP = 2'd2} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;
endpackage

// File: rtl/next_pc_mux.sv
// next_pc_mux: target calc + JR>J>branch priority select; in pc_plus4/run/redirect inputs, out next_pc/trap/redirect
module next_pc_mux
  import mips_pc_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc_plus4,
  input  logic        run,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        branch_taken,
  input  logic [27:0] jump_target28,
  input  logic [31:0] branch_offset,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic        trap,
  output logic        redirect
);
  always_comb begin
    trap = run && jump_reg && |reg_target[1:0];
    redirect = run && (jump_reg || jump || branch_taken);
    next_pc = !run ? pc_plus4 :
              trap ? EXC_VECTOR :
              jump_reg ? reg_target :
              jump ? {pc_plus4[31:28], jump_target28} :
              branch_taken ? pc_plus4 + branch_offset : pc_plus4;
  end
endmodule

// File: rtl/pc_next_sequencer.sv
// pc_next_sequencer: PC/EPC registers + RUN/FLUSH/TRAP FSM; in clk/reset/Stall/redirects/targets, out PC/PCPlus4/Flush/Exception/EPC
module pc_next_sequencer
  import mips_pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        JumpRegister,
  input  logic        BranchTaken,
  input  logic [27:0] JumpTarget28,
  input  logic [31:0] BranchOffset,
  input  logic [31:0] RegisterTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Flush,
  output logic        Exception,
  output logic [31:0] EPC
);
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, epc_q, epc_d, next_pc;
  logic trap, redirect;
  next_pc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_mux (
    .pc_plus4(PCPlus4),
    .run(state_q == RUN),
    .jump(Jump),
    .jump_reg(JumpRegister),
    .branch_taken(BranchTaken),
    .jump_target28(JumpTarget28),
    .branch_offset(BranchOffset),
    .reg_target(RegisterTarget),
    .next_pc(next_pc),
    .trap(trap),
    .redirect(redirect)
  );
  always_comb begin
    PCPlus4 = pc_q + 32'd4;
    pc_d = Stall ? pc_q : next_pc;
    epc_d = (!Stall && trap) ? pc_q : epc_q;
    state_d = Stall ? state_q : trap ? TRAP : redirect ? FLUSH : RUN;
    PC = pc_q;
    EPC = epc_q;
    Flush = (state_q == FLUSH) || (state_q == TRAP);
    Exception = state_q == TRAP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      epc_q <= '0;
      state_q <= RUN;
    end else begin
      pc_q <= pc_d;
      epc_q <= epc_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_pc_next_sequencer.sv
// tb_pc_next_sequencer: directed + random checks of pc_next_sequencer against a behavioural model
module tb_pc_next_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0, Stall = 1'b0, Jump = 1'b0, JumpRegister = 1'b0, BranchTaken = 1'b0;
  logic [27:0] JumpTarget28 = '0;
  logic [31:0] BranchOffset = '0, RegisterTarget = '0;
  logic [31:0] PC, PCPlus4, EPC;
  logic Flush, Exception;
  int tests = 0, fails = 0;
  logic [31:0] m_pc, m_epc;
  logic m_kill, m_exc;

  pc_next_sequencer dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Jump(Jump), .JumpRegister(JumpRegister),
    .BranchTaken(BranchTaken), .JumpTarget28(JumpTarget28), .BranchOffset(BranchOffset),
    .RegisterTarget(RegisterTarget), .PC(PC), .PCPlus4(PCPlus4), .Flush(Flush),
    .Exception(Exception), .EPC(EPC)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic jr, input logic b,
                      input logic [27:0] jt, input logic [31:0] off, input logic [31:0] rt);
    logic [31:0] p4;
    reset = r; Stall = s; Jump = j; JumpRegister = jr; BranchTaken = b;
    JumpTarget28 = jt; BranchOffset = off; RegisterTarget = rt;
    p4 = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0040_0000; m_epc = 0; m_kill = 0; m_exc = 0;
    end else if (!s) begin
      if (m_kill) begin
        m_pc = p4; m_kill = 0; m_exc = 0;
      end else if (jr && rt[1:0] != 2'b00) begin
        m_epc = m_pc; m_pc = 32'h8000_0180; m_kill = 1; m_exc = 1;
      end else if (jr) begin
        m_pc = rt; m_kill = 1;
      end else if (j) begin
        m_pc = {p4[31:28], jt}; m_kill = 1;
      end else if (b) begin
        m_pc = p4 + off; m_kill = 1;
      end else m_pc = p4;
    end
    @(posedge clk);
    #1;
    chk("pc", PC, m_pc);
    chk("pcplus4", PCPlus4, m_pc + 32'd4);
    chk("flush", 32'(Flush), 32'(m_kill));
    chk("exception", 32'(Exception), 32'(m_exc));
    chk("epc", EPC, m_epc);
  endtask

  task automatic free();
    step(0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    m_pc = 0; m_epc = 0; m_kill = 0; m_exc = 0;
    step(1, 0, 0, 0, 0, '0, '0, '0);
    chk("reset_pc", PC, 32'h0040_0000);
    free(); free();
    chk("free_pc2", PC, 32'h0040_0008);
    step(0, 0, 1, 0, 0, 28'h0100020, '0, '0);
    chk("jump_pc", PC, 32'h0010_0020);
    chk("jump_flush", 32'(Flush), 32'd1);
    step(0, 0, 1, 0, 0, 28'h0ABCDE0, '0, '0);
    chk("jump_in_flush_ignored", PC, 32'h0010_0024);
    step(1, 0, 0, 0, 0, '0, '0, '0);
    repeat (4) free();
    step(0, 0, 0, 0, 1, '0, 32'hFFFF_FFF0, '0);
    chk("branch_pc", PC, 32'h0040_0004);
    free(); free(); free();
    step(0, 0, 0, 1, 1, '0, 32'hFFFF_FFF0, 32'h0040_0100);
    chk("jr_wins_pc", PC, 32'h0040_0100);
    step(1, 0, 0, 0, 0, '0, '0, '0);
    repeat (8) free();
    step(0, 0, 1, 1, 1, 28'h0000040, 32'h10, 32'h0040_0102);
    chk("trap_pc", PC, 32'h8000_0180);
    chk("trap_epc", EPC, 32'h0040_0020);
    chk("trap_exc", 32'(Exception), 32'd1);
    free();
    chk("after_trap_pc", PC, 32'h8000_0184);
    repeat (3) step(0, 1, 1, 0, 0, 28'h0000100, '0, '0);
    chk("stall_pc", PC, 32'h8000_0184);
    step(0, 0, 1, 0, 0, 28'h0000100, '0, '0);
    chk("stall_release_jump", PC, 32'h8000_0100);
    step(0, 1, 0, 0, 0, '0, '0, '0);
    chk("stall_flush_held", 32'(Flush), 32'd1);
    step(1, 1, 1, 0, 0, 28'h0000200, '0, '0);
    chk("reset_over_stall", PC, 32'h0040_0000);
    step(0, 0, 0, 1, 0, '0, '0, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", PCPlus4, 32'h0000_0000);
    free();
    chk("wrap_pc", PC, 32'h0000_0000);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(3) != 0) rt[1:0] = 2'b00;
      step($urandom_range(49) == 0, $urandom_range(4) == 0, $urandom_range(5) == 0,
           $urandom_range(7) == 0, $urandom_range(4) == 0, 28'($urandom) & 28'hFFFFFFC,
           $urandom & 32'hFFFF_FFFC, rt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
